// File: rtl/divider_seq.sv
// Iterative restoring divider: one quotient bit per clock behind start/busy/done.
// Define DIVIDER_SIGNED_EN for two's-complement operands (truncating division).
module divider_seq #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] ina,
  input  logic [WIDTH-1:0] inb,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quot,
  output logic [WIDTH-1:0] rem,
  output logic             div_by_zero
);

  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {IDLE, RUN, FIN} state_t;

  state_t         state, state_nxt;
  logic [WIDTH-1:0] qreg, prem, dvs;
  logic [CW-1:0]    cnt;

  logic             accept, zero_div, last;
  logic [WIDTH-1:0] mag_a, mag_b;
  logic [WIDTH:0]   cand, trial;
  logic             pos;
  logic [WIDTH-1:0] nprem, nq, res_q, res_r;

  assign accept   = start && (state != RUN);
  assign zero_div = (inb == '0);
  assign last     = (cnt == CW'(WIDTH-1));

`ifdef DIVIDER_SIGNED_EN
  logic neg_q, neg_r;
  // Magnitudes feed the unsigned core; the most-negative value maps to 2^(WIDTH-1).
  assign mag_a = ina[WIDTH-1] ? -ina : ina;
  assign mag_b = inb[WIDTH-1] ? -inb : inb;
  assign res_q = neg_q ? -nq : nq;
  assign res_r = neg_r ? -nprem : nprem;
`else
  assign mag_a = ina;
  assign mag_b = inb;
  assign res_q = nq;
  assign res_r = nprem;
`endif

  // One restoring step; the trial difference's MSB is its sign.
  assign cand  = {prem, qreg[WIDTH-1]};
  assign trial = cand - {1'b0, dvs};
  assign pos   = ~trial[WIDTH];
  assign nprem = pos ? trial[WIDTH-1:0] : cand[WIDTH-1:0];
  assign nq    = {qreg[WIDTH-2:0], pos};

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE, FIN: begin
        if (accept) state_nxt = zero_div ? FIN : RUN;
        else        state_nxt = IDLE;
      end
      RUN:     if (last) state_nxt = FIN;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    busy = (state == RUN);
    done = (state == FIN);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      qreg        <= '0;
      prem        <= '0;
      dvs         <= '0;
      cnt         <= '0;
      quot        <= '0;
      rem         <= '0;
      div_by_zero <= 1'b0;
`ifdef DIVIDER_SIGNED_EN
      neg_q       <= 1'b0;
      neg_r       <= 1'b0;
`endif
    end else if (accept) begin
      if (zero_div) begin
        quot        <= '1;
        rem         <= ina;
        div_by_zero <= 1'b1;
      end else begin
        qreg <= mag_a;
        dvs  <= mag_b;
        prem <= '0;
        cnt  <= '0;
`ifdef DIVIDER_SIGNED_EN
        neg_q <= ina[WIDTH-1] ^ inb[WIDTH-1];
        neg_r <= ina[WIDTH-1];
`endif
      end
    end else if (state == RUN) begin
      qreg <= nq;
      prem <= nprem;
      cnt  <= cnt + CW'(1);
      if (last) begin
        quot        <= res_q;
        rem         <= res_r;
        div_by_zero <= 1'b0;
      end
    end
  end

endmodule
